pipe_adder: RTL and testbench

- Parametrised, pipelined integer adder/subtractor for the FPU datapath, e.g. mantissa add and exponent difference.
- Splits a WIDTH-bit add into STAGES equal chunks and processes one chunk per cycle, with the ripple carry registered between stages.
- Uses valid/ready handshakes on input and output.
- Reports carry-out and signed overflow.

---
 rtl/pipe_adder_if.sv | 27 ++
 rtl/pipe_adder.sv | 104 ++++++++++
 tb/tb_pipe_adder.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pipe_adder_if.sv
// pipe_adder_if: operand and result bus for pipe_adder.
// Handshake: a beat moves on a rising edge with valid && ready; the source holds payload and valid until then.
interface pipe_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipe_adder.sv
// pipe_adder: STAGES-deep pipelined add/sub, one CW-bit chunk per stage with registered ripple carry.
// Define PIPE_ADDER_SAT_EN to clamp the result to signed saturation on overflow.
module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input logic          clk,
    input logic          rst_n,
    pipe_adder_if.slave  bus
);
    localparam int CW = WIDTH / STAGES;

    logic                          w_en;
    logic [STAGES-1:0]             r_vld;
    logic [STAGES-1:0]             r_c;
    logic [STAGES-1:0][WIDTH-1:0]  r_a;
    logic [STAGES-1:0][WIDTH-1:0]  r_b;
    logic [STAGES-1:0][WIDTH-1:0]  r_sum;
    logic                          r_ovf;

    logic [STAGES-1:0]             w_src_vld;
    logic [STAGES-1:0]             w_src_c;
    logic [STAGES-1:0][WIDTH-1:0]  w_src_a;
    logic [STAGES-1:0][WIDTH-1:0]  w_src_b;
    logic [STAGES-1:0][WIDTH-1:0]  w_src_sum;
    logic [STAGES-1:0]             w_c_nxt;
    logic [STAGES-1:0][WIDTH-1:0]  w_sum_nxt;
    logic                          w_ovf_nxt;
    logic [CW:0]                   w_chunk;
    logic                          w_unused;

    // Whole pipe advances together; it only freezes when a finished result is not taken.
    assign w_en         = !r_vld[STAGES-1] || bus.out_ready;
    assign bus.in_ready = w_en;

    always_comb begin
        w_src_vld = '0;
        w_src_c   = '0;
        w_src_a   = '0;
        w_src_b   = '0;
        w_src_sum = '0;
        w_c_nxt   = '0;
        w_sum_nxt = '0;
        w_chunk   = '0;
        w_ovf_nxt = 1'b0;

        w_src_vld[0] = bus.in_valid;
        w_src_a[0]   = bus.a;
        w_src_b[0]   = bus.sub ? ~bus.b : bus.b;
        w_src_c[0]   = bus.sub | bus.cin;
        for (int s = 1; s < STAGES; s++) begin
            w_src_vld[s] = r_vld[s-1];
            w_src_a[s]   = r_a[s-1];
            w_src_b[s]   = r_b[s-1];
            w_src_c[s]   = r_c[s-1];
            w_src_sum[s] = r_sum[s-1];
        end

        for (int s = 0; s < STAGES; s++) begin
            w_chunk = {1'b0, w_src_a[s][s*CW +: CW]} + {1'b0, w_src_b[s][s*CW +: CW]}
                    + {{CW{1'b0}}, w_src_c[s]};
            w_c_nxt[s]                 = w_chunk[CW];
            w_sum_nxt[s]               = w_src_sum[s];
            w_sum_nxt[s][s*CW +: CW]   = w_chunk[CW-1:0];
        end

        // Overflow: operands agree in sign but the wrapped result does not.
        w_ovf_nxt = (w_src_a[STAGES-1][WIDTH-1] == w_src_b[STAGES-1][WIDTH-1])
                 && (w_sum_nxt[STAGES-1][WIDTH-1] != w_src_a[STAGES-1][WIDTH-1]);
`ifdef PIPE_ADDER_SAT_EN
        if (w_ovf_nxt) begin
            w_sum_nxt[STAGES-1] = w_src_a[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                              : {1'b0, {(WIDTH-1){1'b1}}};
        end
`else
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_c   <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_sum <= '0;
            r_ovf <= 1'b0;
        end else if (w_en) begin
            r_vld <= w_src_vld;
            r_c   <= w_c_nxt;
            r_a   <= w_src_a;
            r_b   <= w_src_b;
            r_sum <= w_sum_nxt;
            r_ovf <= w_ovf_nxt;
        end
    end

    assign bus.out_valid = r_vld[STAGES-1];
    assign bus.sum       = r_sum[STAGES-1];
    assign bus.cout      = r_c[STAGES-1];
    assign bus.ovf       = r_ovf;

    // Chunks already consumed and the final-stage operand copies are never read again.
    assign w_unused = ^{r_a, r_b};
endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed checks of pipe_adder (WIDTH=16, STAGES=4) with a result scoreboard.
module tb_pipe_adder;
    localparam int W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pipe_adder_if #(.WIDTH(W)) bus ();
    pipe_adder #(.WIDTH(W), .STAGES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_tests   = 0;
    int n_fail    = 0;
    int n_retired = 0;
    logic [W+1:0] exp_q[$];
    logic         rdy_rand   = 1'b0;
    logic         prev_stall = 1'b0;
    logic [W+1:0] prev_res   = '0;

    logic [15:0] dv_a[5]   = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h0007};
    logic [15:0] dv_b[5]   = '{16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0005};
    logic        dv_cin[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        dv_sub[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`ifdef PIPE_ADDER_SAT_EN
    logic [17:0] dv_e[5]   = '{18'h1_0000, 18'h2_7FFF, 18'h0_FFFE, 18'h3_8000, 18'h1_0002};
`else
    logic [17:0] dv_e[5]   = '{18'h1_0000, 18'h2_8000, 18'h0_FFFE, 18'h3_7FFF, 18'h1_0002};
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Result monitor: {ovf, cout, sum} against the expected queue, plus stall stability.
    always @(negedge clk) begin
        logic [W+1:0] res;
        #2;
        res = {bus.ovf, bus.cout, bus.sum};
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_hold", 32'(bus.out_valid), 32'd1);
                check("stall_data_hold", 32'(res), 32'(prev_res));
            end
            if (bus.out_valid && !bus.out_ready)
                check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            if (bus.out_valid && bus.out_ready) begin
                n_retired++;
                check("result_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("result", 32'(res), 32'(exp_q.pop_front()));
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_res   = res;
        end
    end

    always @(negedge clk) if (rdy_rand) bus.out_ready = 1'($urandom_range(0, 1));

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic s, input logic [17:0] exp);
        int waits = 0;
        @(negedge clk); #1;
        bus.a = a; bus.b = b; bus.cin = c; bus.sub = s; bus.in_valid = 1'b1;
        while (!bus.in_ready && waits < 200) begin
            @(negedge clk); #1;
            waits++;
        end
        check("accept_timeout", 32'(bus.in_ready), 32'd1);
        if (bus.in_ready) exp_q.push_back(exp);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic drain();
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int lat;
        int base;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
        bus.out_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            send(dv_a[i], dv_b[i], dv_cin[i], dv_sub[i], dv_e[i]);
            wait_valid(lat);
            check("latency", 32'(lat), 32'd3);
            drain();
        end

        // Gapped burst with random back-pressure.
        base = n_retired;
        rdy_rand = 1'b1;
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send(16'(i), 16'(i << 4), 1'b0, 1'b0, {2'b00, 16'(i * 17)});
        end
        rdy_rand = 1'b0;
        bus.out_ready = 1'b1;
        drain();
        check("burst_count", 32'(n_retired - base), 32'd16);

        // Fill under stall, then reset drops everything in flight.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(16'(i + 1), 16'h0001, 1'b0, 1'b0, 18'(i + 2));
        @(negedge clk); #1;
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        check("full_out_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst_sum", 32'(bus.sum), 32'd0);
        exp_q.delete();
        base = n_retired;
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        send(16'h1234, 16'h1111, 1'b0, 1'b0, 18'h0_2345);
        wait_valid(lat);
        check("post_rst_latency", 32'(lat), 32'd3);
        drain();
        check("post_rst_count", 32'(n_retired - base), 32'd1);

        // Long stall, then release with a new beat on the same edge.
        bus.out_ready = 1'b0;
        base = n_retired;
        send(16'h0100, 16'h0023, 1'b0, 1'b0, 18'h0_0123);
        wait_valid(lat);
        repeat (5) @(posedge clk);
        #1;
        check("stall5_valid", 32'(bus.out_valid), 32'd1);
        check("stall5_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        send(16'h0200, 16'h0045, 1'b0, 1'b0, 18'h0_0245);
        check("same_edge_retire", 32'(n_retired - base), 32'd1);
        check("gap_after_retire", 32'(bus.out_valid), 32'd0);
        drain();
        check("release_count", 32'(n_retired - base), 32'd2);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
